// File: rtl/full_adder_unit.sv
// Registered ripple-carry adder assembled from 1-bit full-adder cells.
// {carry_out, sum} = a + b + carry_in, captured one cycle after in_valid.
module full_adder_unit #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             out_valid
);

    // One full-adder cell: returns {carry, sum}.
    function automatic logic [1:0] fa_cell(
        input logic a_bit,
        input logic b_bit,
        input logic c_bit
    );
        logic s_bit;
        logic co_bit;
        s_bit  = a_bit ^ b_bit ^ c_bit;
        co_bit = (a_bit & b_bit) | (a_bit & c_bit) | (b_bit & c_bit);
        return {co_bit, s_bit};
    endfunction

    logic [WIDTH-1:0] sum_s;
    logic             carry_s;
    logic [1:0]       cell_s;

    logic [WIDTH-1:0] sum_r;
    logic             carry_out_r;
    logic             out_valid_r;

    // Ripple the carry through the cell chain, bit 0 first.
    always_comb begin
        sum_s   = {WIDTH{1'b0}};
        cell_s  = 2'b00;
        carry_s = carry_in;
        for (int i = 0; i < WIDTH; i++) begin
            cell_s   = fa_cell(a[i], b[i], carry_s);
            sum_s[i] = cell_s[0];
            carry_s  = cell_s[1];
        end
    end

    // Result registers; operands are only sampled when in_valid is high,
    // so undriven inputs during idle cycles cannot reach the held result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_r       <= {WIDTH{1'b0}};
            carry_out_r <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= in_valid;
            if (in_valid) begin
                sum_r       <= sum_s;
                carry_out_r <= carry_s;
            end
        end
    end

    assign sum       = sum_r;
    assign carry_out = carry_out_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_full_adder_unit.sv
// Directed self-checking bench for full_adder_unit at WIDTH=1 and WIDTH=4.
module tb_full_adder_unit;

    logic       clk;
    logic       rst_n;

    logic       v1_in;
    logic       a1;
    logic       b1;
    logic       c1;
    logic       s1;
    logic       co1;
    logic       v1_out;

    logic       v4_in;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       c4;
    logic [3:0] s4;
    logic       co4;
    logic       v4_out;

    int check_cnt = 0;
    int pass_cnt  = 0;

    // Expected {cout,sum} for {a,b,cin} = 0..7, worked out by hand.
    logic [1:0] tbl_w1 [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};

    full_adder_unit #(.WIDTH(1)) u_w1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v1_in),
        .a         (a1),
        .b         (b1),
        .carry_in  (c1),
        .sum       (s1),
        .carry_out (co1),
        .out_valid (v1_out)
    );

    full_adder_unit #(.WIDTH(4)) u_w4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v4_in),
        .a         (a4),
        .b         (b4),
        .carry_in  (c4),
        .sum       (s4),
        .carry_out (co4),
        .out_valid (v4_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        check_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic v, input logic a, input logic b, input logic c);
        v1_in = v;
        a1    = a;
        b1    = b;
        c1    = c;
    endtask

    task automatic drive4(input logic v, input logic [3:0] a, input logic [3:0] b, input logic c);
        v4_in = v;
        a4    = a;
        b4    = b;
        c4    = c;
    endtask

    initial begin
        rst_n = 1'b0;
        drive1(1'b0, 1'b0, 1'b0, 1'b0);
        drive4(1'b0, 4'h0, 4'h0, 1'b0);
        tick();
        tick();
        check("rst_w1", {5'd0, v1_out, co1, s1}, 8'h00);
        check("rst_w4", {2'd0, v4_out, co4, s4}, 8'h00);

        // Single-bit basics
        rst_n = 1'b1;
        drive1(1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        check("w1_100", {5'd0, v1_out, co1, s1}, 8'b101);
        drive1(1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        check("w1_110", {5'd0, v1_out, co1, s1}, 8'b110);
        drive1(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check("w1_000", {5'd0, v1_out, co1, s1}, 8'b100);

        // All eight combinations back-to-back
        for (int i = 0; i < 8; i++) begin
            drive1(1'b1, i[2], i[1], i[0]);
            tick();
            check($sformatf("w1_combo%0d", i), {5'd0, v1_out, co1, s1}, {5'd0, 1'b1, tbl_w1[i]});
        end

        // Four-bit vectors including carry-out boundary
        drive4(1'b1, 4'hF, 4'h1, 1'b0);
        tick();
        check("w4_f_1_0", {2'd0, v4_out, co4, s4}, 8'h30);
        drive4(1'b1, 4'h7, 4'h8, 1'b1);
        tick();
        check("w4_7_8_1", {2'd0, v4_out, co4, s4}, 8'h30);
        drive4(1'b1, 4'h3, 4'h4, 1'b0);
        tick();
        check("w4_3_4_0", {2'd0, v4_out, co4, s4}, 8'h27);
        drive4(1'b1, 4'hA, 4'h5, 1'b1);
        tick();
        check("w4_a_5_1", {2'd0, v4_out, co4, s4}, 8'h30);
        drive4(1'b1, 4'h9, 4'h3, 1'b0);
        tick();
        check("w4_9_3_0", {2'd0, v4_out, co4, s4}, 8'h2C);
        drive4(1'b1, 4'hF, 4'hF, 1'b1);
        tick();
        check("w4_f_f_1", {2'd0, v4_out, co4, s4}, 8'h3F);

        // Load then idle with unknown operands: outputs held, valid drops
        drive1(1'b1, 1'b1, 1'b1, 1'b0);
        drive4(1'b1, 4'h5, 4'h6, 1'b0);
        tick();
        check("hold_load_w1", {5'd0, v1_out, co1, s1}, 8'b110);
        check("hold_load_w4", {2'd0, v4_out, co4, s4}, 8'h2B);
        for (int k = 0; k < 3; k++) begin
            drive1(1'b0, 1'bx, 1'bx, 1'bx);
            drive4(1'b0, 4'bxxxx, 4'bxxxx, 1'bx);
            tick();
            check($sformatf("hold_w1_%0d", k), {5'd0, v1_out, co1, s1}, 8'b010);
            check($sformatf("hold_w4_%0d", k), {2'd0, v4_out, co4, s4}, 8'h0B);
        end

        // Reset overrides a valid operand on the same edge
        rst_n = 1'b0;
        drive1(1'b1, 1'b1, 1'b1, 1'b1);
        drive4(1'b1, 4'hF, 4'hF, 1'b1);
        tick();
        check("rst_mid_w1", {5'd0, v1_out, co1, s1}, 8'h00);
        check("rst_mid_w4", {2'd0, v4_out, co4, s4}, 8'h00);

        // Recovery after reset
        rst_n = 1'b1;
        drive1(1'b1, 1'b0, 1'b1, 1'b1);
        drive4(1'b1, 4'h8, 4'h8, 1'b0);
        tick();
        check("post_rst_w1", {5'd0, v1_out, co1, s1}, 8'b110);
        check("post_rst_w4", {2'd0, v4_out, co4, s4}, 8'h30);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
